lector_destinos: RTL and testbench

- Consumer at the output side of the interconnect device. It drains destination FIFOs D0 and D1 by driving pop_D0/pop_D1, captures the returned words and checks each word's destination bit.
- It keeps per-destination receive counts and an error count.
- It is the read-side counterpart of the stimulus that pushes into the main FIFO. It is used as the bench sink and as the on-chip drain for loopback.

---
 rtl/lector_destinos.sv | 144 ++++++++++++++
 tb/tb_lector_destinos.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lector_destinos.sv
// Drain side of the interconnect: arbitrates pops between destination FIFOs D0/D1,
// captures returned words two clocks later and checks each word's destination bit.
module lector_destinos #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              init,
  input  logic              empty_d0,
  input  logic              empty_d1,
  input  logic              almost_empty_d0,
  input  logic              almost_empty_d1,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [DATA_W-1:0] data_rx,
  output logic              valid_rx,
  output logic              src_rx,
  output logic [CNT_W-1:0]  count_d0,
  output logic [CNT_W-1:0]  count_d1,
  output logic [CNT_W-1:0]  err_count,
  output logic              dest_error
);

  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t          state, state_n;
  logic            last_served, last_n;
  logic [BW-1:0]   burst_cnt, burst_n;
  logic            pop0_n, pop1_n;
  logic            elig0, elig1, burst_max;
  logic            tag_vld, tag_src;
  logic [DATA_W-1:0] cap_word;
  logic            mismatch;

  // A pop already in flight consumes one word, so keep popping only above the threshold.
  assign elig0     = !empty_d0 && (!pop_D0 || !almost_empty_d0);
  assign elig1     = !empty_d1 && (!pop_D1 || !almost_empty_d1);
  assign burst_max = (burst_cnt == BW'(BURST));

  always_comb begin
    state_n = state;
    last_n  = last_served;
    burst_n = burst_cnt;
    pop0_n  = 1'b0;
    pop1_n  = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (elig0 && (last_served || !elig1)) begin
            state_n = SERVE0; last_n = 1'b0; pop0_n = 1'b1; burst_n = BW'(1);
          end else if (elig1) begin
            state_n = SERVE1; last_n = 1'b1; pop1_n = 1'b1; burst_n = BW'(1);
          end
        end
        SERVE0: begin
          if ((burst_max && !empty_d1) || (!elig0 && elig1)) begin
            state_n = SERVE1; last_n = 1'b1; pop1_n = 1'b1; burst_n = BW'(1);
          end else if (elig0) begin
            pop0_n  = 1'b1;
            burst_n = burst_max ? burst_cnt : burst_cnt + BW'(1);
          end else begin
            state_n = IDLE; burst_n = '0;
          end
        end
        SERVE1: begin
          if ((burst_max && !empty_d0) || (!elig1 && elig0)) begin
            state_n = SERVE0; last_n = 1'b0; pop0_n = 1'b1; burst_n = BW'(1);
          end else if (elig1) begin
            pop1_n  = 1'b1;
            burst_n = burst_max ? burst_cnt : burst_cnt + BW'(1);
          end else begin
            state_n = IDLE; burst_n = '0;
          end
        end
        default: begin
          state_n = IDLE; burst_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b0;
      burst_cnt   <= '0;
      pop_D0      <= 1'b0;
      pop_D1      <= 1'b0;
    end else begin
      state       <= state_n;
      last_served <= last_n;
      burst_cnt   <= burst_n;
      pop_D0      <= pop0_n;
      pop_D1      <= pop1_n;
    end
  end

  // Tag stage lines up with the FIFO's registered read data one edge after the pop.
  assign cap_word = tag_src ? data_out1 : data_out0;
  assign mismatch = (cap_word[4] != tag_src);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld    <= 1'b0;
      tag_src    <= 1'b0;
      valid_rx   <= 1'b0;
      src_rx     <= 1'b0;
      data_rx    <= '0;
      count_d0   <= '0;
      count_d1   <= '0;
      err_count  <= '0;
      dest_error <= 1'b0;
    end else begin
      tag_vld  <= pop_D0 | pop_D1;
      tag_src  <= pop_D1;
      valid_rx <= tag_vld;
      if (tag_vld) begin
        data_rx <= cap_word;
        src_rx  <= tag_src;
      end
      if (init) begin
        count_d0   <= '0;
        count_d1   <= '0;
        err_count  <= '0;
        dest_error <= 1'b0;
      end else if (tag_vld) begin
        if (!tag_src && count_d0 != '1) count_d0 <= count_d0 + CNT_W'(1);
        if (tag_src && count_d1 != '1)  count_d1 <= count_d1 + CNT_W'(1);
        if (mismatch) begin
          dest_error <= 1'b1;
          if (err_count != '1) err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lector_destinos.sv
// Directed bench: behavioural D0/D1 FIFOs with registered read data drive two
// instances (CNT_W=8 and CNT_W=4) sharing all inputs.
module tb_lector_destinos;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       init = 1'b0;
  logic       empty_d0, empty_d1, almost_empty_d0, almost_empty_d1;
  logic [5:0] data_out0 = '0;
  logic [5:0] data_out1 = '0;

  logic       pop_D0, pop_D1, valid_rx, src_rx, dest_error;
  logic [5:0] data_rx;
  logic [7:0] count_d0, count_d1, err_count;

  logic       p0_4, p1_4, v_4, s_4, de_4;
  logic [5:0] d_4;
  logic [3:0] c0_4, c1_4, e_4;

  always #5 clk = ~clk;

  lector_destinos #(.DATA_W(6), .CNT_W(8), .BURST(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .init(init),
    .empty_d0(empty_d0), .empty_d1(empty_d1),
    .almost_empty_d0(almost_empty_d0), .almost_empty_d1(almost_empty_d1),
    .data_out0(data_out0), .data_out1(data_out1),
    .pop_D0(pop_D0), .pop_D1(pop_D1), .data_rx(data_rx), .valid_rx(valid_rx),
    .src_rx(src_rx), .count_d0(count_d0), .count_d1(count_d1),
    .err_count(err_count), .dest_error(dest_error));

  lector_destinos #(.DATA_W(6), .CNT_W(4), .BURST(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .init(init),
    .empty_d0(empty_d0), .empty_d1(empty_d1),
    .almost_empty_d0(almost_empty_d0), .almost_empty_d1(almost_empty_d1),
    .data_out0(data_out0), .data_out1(data_out1),
    .pop_D0(p0_4), .pop_D1(p1_4), .data_rx(d_4), .valid_rx(v_4),
    .src_rx(s_4), .count_d0(c0_4), .count_d1(c1_4),
    .err_count(e_4), .dest_error(de_4));

  // FIFO models: read data updates on the edge that consumes a pop.
  logic [5:0] mem0 [256];
  logic [5:0] mem1 [256];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int umbral = 1;
  int underflow = 0;

  assign empty_d0        = (rd0 == wr0);
  assign empty_d1        = (rd1 == wr1);
  assign almost_empty_d0 = ((wr0 - rd0) <= umbral);
  assign almost_empty_d1 = ((wr1 - rd1) <= umbral);

  always @(posedge clk) begin
    if (pop_D0) begin
      if (rd0 < wr0) begin
        data_out0 <= mem0[rd0];
        rd0 <= rd0 + 1;
      end else underflow <= underflow + 1;
    end
    if (pop_D1) begin
      if (rd1 < wr1) begin
        data_out1 <= mem1[rd1];
        rd1 <= rd1 + 1;
      end else underflow <= underflow + 1;
    end
  end

  // Monitor: captures and pop sequence sampled on the falling edge.
  logic [5:0] cap_d[$];
  logic       cap_s[$];
  logic       pop_seq[$];
  int         both_seen = 0;

  always @(negedge clk) begin
    if (valid_rx) begin
      cap_d.push_back(data_rx);
      cap_s.push_back(src_rx);
    end
    if (pop_D0) pop_seq.push_back(1'b0);
    if (pop_D1) pop_seq.push_back(1'b1);
    if (pop_D0 && pop_D1) both_seen++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {29'd0, pop_D0, pop_D1, valid_rx, src_rx, data_rx,
            count_d0, count_d1, err_count, dest_error};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push0(input logic [5:0] v);
    mem0[wr0] = v;
    wr0++;
  endtask

  task automatic push1(input logic [5:0] v);
    mem1[wr1] = v;
    wr1++;
  endtask

  task automatic clear_logs();
    cap_d.delete();
    cap_s.delete();
    pop_seq.delete();
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick(1);
    init = 1'b0;
  endtask

  function automatic int n_pops(input logic src);
    int n = 0;
    foreach (pop_seq[i]) if (pop_seq[i] == src) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] pat;

    // Reset and idle
    tick(3);
    chk("reset_outs", outs(), 64'd0);
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_outs", outs(), 64'd0);
    end

    // Drain D0
    pulse_init();
    clear_logs();
    for (int i = 1; i <= 15; i++) push0(6'(i));
    tick(30);
    chk("d0_ncap", cap_d.size(), 15);
    for (int i = 0; i < 15 && i < cap_d.size(); i++)
      chk("d0_cap", {cap_s[i], cap_d[i]}, {1'b0, 6'(i + 1)});
    chk("d0_count", count_d0, 15);
    chk("d0_err", err_count, 0);
    chk("d0_pops", n_pops(1'b0), 15);
    chk("underflow", underflow, 0);

    // Drain D1
    pulse_init();
    clear_logs();
    for (int i = 1; i <= 15; i++) push1(6'(8'h30 + i));
    tick(30);
    chk("d1_ncap", cap_d.size(), 15);
    for (int i = 0; i < 15 && i < cap_d.size(); i++)
      chk("d1_cap", {cap_s[i], cap_d[i]}, {1'b1, 6'(8'h30 + i + 1)});
    chk("d1_count", count_d1, 15);
    chk("d1_d0pops", n_pops(1'b0), 0);
    chk("d1_err", err_count, 0);

    // Arbitration: 4x D0, 4x D1, 4x D0, 4x D1, 2x D0, 2x D1
    pulse_init();
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      push0(6'(i));
      push1(6'(8'h10 + i));
    end
    tick(40);
    pat = '0;
    foreach (pop_seq[i]) pat = {pat[30:0], pop_seq[i]};
    chk("arb_npops", pop_seq.size(), 20);
    chk("arb_pattern", pat, 32'h0F0F3);
    chk("arb_both", both_seen, 0);
    chk("arb_counts", {count_d0, count_d1}, {8'd10, 8'd10});
    chk("arb_err", err_count, 0);
    chk("underflow", underflow, 0);

    // Underflow guard: single word, already almost empty
    pulse_init();
    clear_logs();
    push0(6'h05);
    tick(10);
    chk("uf_pops", pop_seq.size(), 1);
    chk("uf_ncap", cap_d.size(), 1);
    chk("underflow", underflow, 0);

    // Destination mismatch
    pulse_init();
    clear_logs();
    push0(6'h12);
    tick(10);
    chk("err_cap", (cap_d.size() == 1) ? {cap_s[0], cap_d[0]} : 7'h7F, {1'b0, 6'h12});
    chk("err_count", err_count, 1);
    chk("err_sticky", dest_error, 1);
    chk("err_cnt_d0", count_d0, 1);

    // Saturation on the 4-bit instance, no init since the error test
    clear_logs();
    for (int i = 0; i < 20; i++) push0(6'(i & 15));
    tick(40);
    chk("sat_c4", c0_4, 15);
    chk("sat_c8", count_d0, 21);
    chk("sat_err4", e_4, 1);
    chk("sat_de4", de_4, 1);

    // init clears counters and sticky error
    pulse_init();
    chk("init_clr", {count_d0, count_d1, err_count, 7'd0, dest_error}, 32'd0);
    chk("init_clr4", {c0_4, c1_4, e_4, de_4}, 13'd0);

    // Reset mid-burst: in-flight reads are dropped; enable=0 stops pops
    clear_logs();
    for (int i = 0; i < 8; i++) push0(6'(i));
    tick(3);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", outs(), 64'd0);
    enable = 1'b0;
    tick(2);
    reset = 1'b0;
    clear_logs();
    tick(6);
    chk("rst_mid_ncap", cap_d.size(), 0);
    chk("dis_pops", pop_seq.size(), 0);
    chk("underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
